// File: rtl/elastic_fifo.sv
// Elastic FIFO: DEPTH_P-entry valid/ready buffer with an occupancy count, a
// synchronous flush and an optional ready pass-through while full.
module elastic_fifo #(
    parameter int WIDTH_P          = 8,
    parameter int DEPTH_P          = 4,
    parameter int READY_PASSTHRU_P = 0
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic [WIDTH_P-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [WIDTH_P-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH_P + 1);
    localparam int PTR_W = $clog2(DEPTH_P);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Pointers wrap explicitly so DEPTH_P need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH_P - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full  = (count == cnt_t'(DEPTH_P));
    assign empty = (count == '0);

    assign ready_o = (~full | ((READY_PASSTHRU_P != 0) & ready_i)) & ~flush_i;
    assign valid_o = ~empty & ~flush_i;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign count_o = count;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a full-and-popping push reuses the head slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && full && !pop));

    no_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(pop && empty));

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: four instances (depth/mode mix) share one stimulus
// stream; a sequence-number model predicts every output each cycle.
module tb_elastic_fifo;

    localparam int N_INST = 4;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data  = 8'h00;

    logic       rdy_o [N_INST];
    logic       vld_o [N_INST];
    logic [7:0] dat_o [N_INST];
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] cnt_d;

    int depth_m [N_INST] = '{4, 4, 3, 2};
    int mode_m  [N_INST] = '{0, 1, 1, 0};
    int pushes  [N_INST];
    int pops    [N_INST];
    logic [7:0] store [N_INST][256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elastic_fifo #(.WIDTH_P(8), .DEPTH_P(4), .READY_PASSTHRU_P(0)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .data_i(data), .valid_i(valid),
        .ready_o(rdy_o[0]), .valid_o(vld_o[0]), .data_o(dat_o[0]), .ready_i(ready),
        .count_o(cnt_a));

    elastic_fifo #(.WIDTH_P(8), .DEPTH_P(4), .READY_PASSTHRU_P(1)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .data_i(data), .valid_i(valid),
        .ready_o(rdy_o[1]), .valid_o(vld_o[1]), .data_o(dat_o[1]), .ready_i(ready),
        .count_o(cnt_b));

    elastic_fifo #(.WIDTH_P(8), .DEPTH_P(3), .READY_PASSTHRU_P(1)) dut_c (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .data_i(data), .valid_i(valid),
        .ready_o(rdy_o[2]), .valid_o(vld_o[2]), .data_o(dat_o[2]), .ready_i(ready),
        .count_o(cnt_c));

    elastic_fifo #(.WIDTH_P(8), .DEPTH_P(2), .READY_PASSTHRU_P(0)) dut_d (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .data_i(data), .valid_i(valid),
        .ready_o(rdy_o[3]), .valid_o(vld_o[3]), .data_o(dat_o[3]), .ready_i(ready),
        .count_o(cnt_d));

    function automatic int act_count(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    // Model: occupancy is simply words accepted minus words delivered.
    function automatic int occ(input int i);
        return pushes[i] - pops[i];
    endfunction

    function automatic logic exp_valid(input int i);
        return (occ(i) != 0) && !flush;
    endfunction

    function automatic logic exp_ready(input int i);
        return ((occ(i) < depth_m[i]) || (mode_m[i] != 0 && ready)) && !flush;
    endfunction

    function automatic logic [7:0] exp_data(input int i);
        return exp_valid(i) ? store[i][pops[i] % 256] : 8'h00;
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < N_INST; i++) begin
            if (!rstn || flush) begin
                pushes[i] = 0;
                pops[i]   = 0;
            end else begin
                logic p;
                logic q;
                p = valid && exp_ready(i);
                q = exp_valid(i) && ready;
                if (p) begin
                    store[i][pushes[i] % 256] = data;
                    pushes[i]++;
                end
                if (q) begin
                    pops[i]++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s inst%0d got=%0h want=%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < N_INST; i++) begin
                checkOutput("model_count", i, act_count(i), occ(i));
                checkOutput("model_valid", i, vld_o[i], exp_valid(i));
                checkOutput("model_data", i, dat_o[i], exp_data(i));
                checkOutput("model_ready", i, rdy_o[i], exp_ready(i));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic r, input logic f);
        valid = v;
        data  = d;
        ready = r;
        flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (10) tick();
    endtask

    logic [7:0] exp3 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};

    initial begin
        // Reset held for three cycles, then released.
        rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            checkOutput("rst_valid", 0, vld_o[0], 0);
            checkOutput("rst_data", 0, dat_o[0], 0);
            checkOutput("rst_count", 0, act_count(0), 0);
        end
        rstn = 1'b1;
        #1;
        checkOutput("rst_ready", 0, rdy_o[0], 1);
        checkOutput("rst_ready", 1, rdy_o[1], 1);

        // Fill with the sink stalled, then drain.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0);
            tick();
            checkOutput("fill_count", 0, act_count(0), k + 1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_ready", 0, rdy_o[0], 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_data", 0, dat_o[0], 8'h11 * (k + 1));
            tick();
        end
        checkOutput("drain_count", 0, act_count(0), 0);
        drain();

        // Full FIFO pushed and popped in the same cycle (pass-through mode).
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
            tick();
        end
        checkOutput("pt_full_count", 1, act_count(1), 4);
        applyStimulus(1'b1, 8'hB0, 1'b1, 1'b0);
        checkOutput("pt_ready", 1, rdy_o[1], 1);
        checkOutput("pt_head", 1, dat_o[1], 8'hA0);
        checkOutput("m0_full_ready", 0, rdy_o[0], 0);
        tick();
        checkOutput("pt_count", 1, act_count(1), 4);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("pt_order", 1, dat_o[1], exp3[k]);
            tick();
        end
        checkOutput("pt_empty", 1, act_count(1), 0);
        drain();

        // Streaming at one word per cycle.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
            tick();
            checkOutput("stream_count", 0, act_count(0), 1);
            checkOutput("stream_data", 0, dat_o[0], 8'h40 + k);
        end
        drain();

        // Flush from three entries, then a fresh push.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'(8'h70 + k), 1'b0, 1'b0);
            tick();
        end
        checkOutput("pre_flush_count", 0, act_count(0), 3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flush_ready", 0, rdy_o[0], 0);
        checkOutput("flush_valid", 0, vld_o[0], 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_flush_count", 0, act_count(0), 0);
        checkOutput("post_flush_valid", 0, vld_o[0], 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("after_flush_valid", 0, vld_o[0], 1);
        checkOutput("after_flush_data", 0, dat_o[0], 8'h5A);
        drain();

        // Random traffic with phase-varying backpressure and one async reset.
        for (int c = 0; c < 10000; c++) begin
            int rdy_pct;
            rdy_pct = 20 + 30 * ((c / 1000) % 3);
            applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 99) < rdy_pct) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            tick();
            if (c == 5000) begin
                #2;
                rstn = 1'b0;
                #1;
                for (int i = 0; i < N_INST; i++) begin
                    checkOutput("async_rst_count", i, act_count(i), 0);
                    checkOutput("async_rst_valid", i, vld_o[i], 0);
                    checkOutput("async_rst_data", i, dat_o[i], 0);
                end
                tick();
                tick();
                rstn = 1'b1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
